uart_rx_cfg: RTL

Parametrised, runtime-configurable UART receiver. It is the next-generation replacement for the fixed 8N1 receiver in the UART subsystem. It adds configurable data width, optional even/odd parity, 1 or 2 stop bits, an input synchroniser, 3-sample majority filtering, and per-frame parity, framing and break status. It sits between the RX pad and the host-side RX FIFO / CPU register interface.

---
 rtl/uart_rx_cfg.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: synchroniser, 3-sample majority filter,
// 5..9 data bits, optional even/odd parity, 1 or 2 stop bits, break detect.
module uart_rx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  input  logic [15:0]          CLKS_PER_BIT,
  input  logic                 i_Parity_En,
  input  logic                 i_Parity_Odd,
  input  logic                 i_Two_Stop,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break
);

  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, CLEANUP, WAIT_IDLE
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             vote_q;
  logic                   sample;

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shadow_q, shadow_d;
  logic                   par_err_q, par_err_d;
  logic                   par_bit_q, par_bit_d;
  logic                   frm_err_q, frm_err_d;
  logic                   brk_q, brk_d;

  logic [15:0]            cpb_q, cpb_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   two_stop_q, two_stop_d;

  logic                   dv_q, dv_d;
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   brko_q, brko_d;

  logic                   bit_end;
  logic [15:0]            half_cnt;
  logic                   fin, fin_frm, fin_brk, stop1_brk;

  // A lone glitch in the 3-deep window is outvoted by the other two samples.
  assign sample   = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
  assign bit_end  = (cnt_q == cpb_q - 16'd1);
  assign half_cnt = (cpb_q - 16'd1) >> 1;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shadow_d   = shadow_q;
    par_err_d  = par_err_q;
    par_bit_d  = par_bit_q;
    frm_err_d  = frm_err_q;
    brk_d      = brk_q;
    cpb_d      = cpb_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    dv_d       = 1'b0;
    byte_d     = byte_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brko_d     = brko_q;
    fin        = 1'b0;
    fin_frm    = 1'b0;
    fin_brk    = 1'b0;
    stop1_brk  = (shadow_q == '0) && (!par_en_q || !par_bit_q) && !sample;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sample) begin
          state_d    = START;
          cpb_d      = CLKS_PER_BIT;
          par_en_d   = i_Parity_En;
          par_odd_d  = i_Parity_Odd;
          two_stop_d = i_Two_Stop;
          par_err_d  = 1'b0;
          par_bit_d  = 1'b0;
          frm_err_d  = 1'b0;
          brk_d      = 1'b0;
        end
      end
      START: begin
        if (cnt_q == half_cnt) begin
          cnt_d   = '0;
          state_d = sample ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d            = '0;
          shadow_d[bit_q]  = sample;
          if (bit_q == IDX_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP1;
          end else begin
            bit_d = bit_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d     = '0;
          par_bit_d = sample;
          par_err_d = sample != ((^shadow_q) ^ par_odd_q);
          state_d   = STOP1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP1: begin
        if (bit_end) begin
          cnt_d     = '0;
          frm_err_d = frm_err_q | !sample;
          brk_d     = stop1_brk;
          if (two_stop_q) begin
            state_d = STOP2;
          end else begin
            fin     = 1'b1;
            fin_frm = frm_err_q | !sample;
            fin_brk = stop1_brk;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP2: begin
        if (bit_end) begin
          cnt_d   = '0;
          fin     = 1'b1;
          fin_frm = frm_err_q | !sample;
          fin_brk = brk_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CLEANUP:   state_d = IDLE;
      WAIT_IDLE: if (sample) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // A break frame reports framing only; its parity result is meaningless.
    if (fin) begin
      dv_d    = 1'b1;
      byte_d  = shadow_q;
      perr_d  = par_err_q & !fin_brk;
      ferr_d  = fin_frm;
      brko_d  = fin_brk;
      state_d = fin_brk ? WAIT_IDLE : CLEANUP;
    end
  end

  always_ff @(posedge i_Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_Reset) begin
      sync_q     <= '1;
      vote_q     <= 3'b111;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shadow_q   <= '0;
      par_err_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      brk_q      <= 1'b0;
      cpb_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      dv_q       <= 1'b0;
      byte_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brko_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], i_RX_Serial};
      vote_q     <= {vote_q[1:0], sync_q[SYNC_STAGES-1]};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shadow_q   <= shadow_d;
      par_err_q  <= par_err_d;
      par_bit_q  <= par_bit_d;
      frm_err_q  <= frm_err_d;
      brk_q      <= brk_d;
      cpb_q      <= cpb_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      dv_q       <= dv_d;
      byte_q     <= byte_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brko_q     <= brko_d;
    end
  end

  assign o_RX_DV      = dv_q;
  assign o_RX_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Break      = brko_q;

endmodule
